// File: rtl/serpent_decrypt_iter.sv
// serpent_decrypt_iter: iterative Serpent-256 block decryptor, one inverse round per clock
module serpent_decrypt_iter #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [127:0]     subkeys [0:32],
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [0:7][63:0] SI_TAB = {
    64'hD3B0A65C1E47F982, 64'h582EF6C3B4791DA0, 64'hC9F4BE12036D58A7, 64'h09A7BE6D35C248F1,
    64'h5083A97E2CB64FD1, 64'h8F2941DEB6537CA0, 64'hFA1D536049E72C8B, 64'h306D9EF85CB7A142
  };
  state_t             state, state_n;
  logic [4:0]         rnd, ksel;
  logic [127:0]       st, x, dp;
  logic [127:0]       sb [8];
  logic [TAG_W-1:0]   tag_q;
  logic               load;

  function automatic logic [127:0] inv_sbox(input logic [63:0] t, input logic [127:0] s);
    logic [127:0] r;
    logic [3:0]   v, y;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      v = {s[96+i], s[64+i], s[32+i], s[i]};
      y = t[60-4*int'(v) +: 4];
      {r[96+i], r[64+i], r[32+i], r[i]} = y;
    end
    return r;
  endfunction

  function automatic logic [127:0] ilt(input logic [127:0] s);
    logic [31:0] a, b, c, d;
    {d, c, b, a} = s;
    c = {c[21:0], c[31:22]};
    a = {a[4:0], a[31:5]};
    c = c ^ d ^ (b << 7);
    a = a ^ b ^ d;
    d = {d[6:0], d[31:7]};
    b = {b[0], b[31:1]};
    d = d ^ c ^ (a << 3);
    b = b ^ a ^ c;
    c = {c[2:0], c[31:3]};
    a = {a[12:0], a[31:13]};
    return {d, c, b, a};
  endfunction

  always_comb begin
    in_ready  = (state == IDLE) || (state == DONE && out_ready);
    load      = in_valid && in_ready;
    out_valid = state == DONE;
    busy      = state == RUN;
    out_data  = out_valid ? st : '0;
    out_tag   = out_valid ? tag_q : '0;
    ksel      = load ? 5'd31 : rnd;
    x         = load ? in_data ^ subkeys[32] : ilt(st);
    for (int k = 0; k < 8; k++) sb[k] = inv_sbox(SI_TAB[k], x);
    dp        = sb[ksel[2:0]] ^ subkeys[ksel];
    state_n   = state;
    case (state)
      IDLE:    state_n = load ? RUN : IDLE;
      RUN:     state_n = (rnd == 5'd0) ? DONE : RUN;
      DONE:    state_n = out_ready ? (in_valid ? RUN : IDLE) : DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd   <= '0;
      st    <= '0;
      tag_q <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        st    <= dp;
        rnd   <= 5'd30;
        tag_q <= in_tag;
      end else if (state == RUN) begin
        st  <= dp;
        rnd <= (rnd == 5'd0) ? rnd : rnd - 5'd1;
      end
    end
  end
endmodule

// File: tb/tb_serpent_decrypt_iter.sv
// tb_serpent_decrypt_iter: directed and randomised encrypt-then-decrypt checks of serpent_decrypt_iter
`define CHK(tag, got, exp) begin checks++; assert ((got) === (exp)) else begin errors++; $error("FAIL %s: got %0h expected %0h", tag, got, exp); end end

module tb_serpent_decrypt_iter;
  localparam logic [63:0] S_TAB [8] = '{
    64'h38F1A65BED42709C, 64'hFC27905A1BE86D34, 64'h86793CAFD1E40B52, 64'h0FB8C963D124A75E,
    64'h1F83C0B6254A9E7D, 64'hF52B4A9C03E8D671, 64'h72C5846BE91FD3A0, 64'h1DF0E82B74CA9356
  };
  logic         clk = 1'b0, rst_n = 1'b1;
  logic [127:0] sk [0:32];
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [127:0] in_data = '0, out_data;
  logic [7:0]   in_tag = '0, out_tag;
  int           checks = 0, errors = 0, bad = 0;

  serpent_decrypt_iter #(.TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .subkeys(sk),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rol(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [127:0] sbox(input int k, input logic [127:0] s);
    logic [127:0] r;
    logic [3:0]   v, y;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      v = {s[96+i], s[64+i], s[32+i], s[i]};
      y = S_TAB[k][60-4*int'(v) +: 4];
      r[i] = y[0]; r[32+i] = y[1]; r[64+i] = y[2]; r[96+i] = y[3];
    end
    return r;
  endfunction

  function automatic logic [127:0] lt(input logic [127:0] s);
    logic [31:0] a, b, c, d;
    {d, c, b, a} = s;
    a = rol(a, 13); c = rol(c, 3);
    b = b ^ a ^ c; d = d ^ c ^ (a << 3);
    b = rol(b, 1); d = rol(d, 7);
    a = a ^ b ^ d; c = c ^ d ^ (b << 7);
    a = rol(a, 5); c = rol(c, 22);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt);
    logic [127:0] v;
    v = pt;
    for (int r = 0; r < 32; r++) begin
      v = sbox(r % 8, v ^ sk[r]);
      v = (r < 31) ? lt(v) : v ^ sk[32];
    end
    return v;
  endfunction

  task automatic keysched(input logic [255:0] key);
    logic [31:0] w [140];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
    for (int i = 8; i < 140; i++) begin
      t = w[i-8] ^ w[i-5] ^ w[i-3] ^ w[i-1] ^ 32'h9E3779B9 ^ 32'(i - 8);
      w[i] = rol(t, 11);
    end
    for (int k = 0; k < 33; k++)
      sk[k] = sbox((35 - k) % 8, {w[8+4*k+3], w[8+4*k+2], w[8+4*k+1], w[8+4*k]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      step();
      cnt++;
      if (!out_valid && in_ready !== 1'b0) bad++;
    end
    `CHK("out_valid_timeout", out_valid, 1'b1)
  endtask

  initial begin
    logic [127:0] pts [3];
    logic [127:0] cts [3];
    logic [127:0] pa, pb, pc, pd, ptr;
    logic [135:0] cur, expv;
    logic [135:0] q [$];
    logic         acc, take;
    int           n, sent, got, cyc;
    pts = '{128'h00112233445566778899AABBCCDDEEFF, {128{1'b1}}, 128'h80000000000000000000000000000001};
    pa = 128'hDEADBEEF0BADF00DCAFEBABE12345678;
    pb = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    pc = 128'h55AA55AA00FF00FF123456789ABCDEF0;
    pd = 128'hA5A5A5A5C3C3C3C3F0F0F0F01E1E1E1E;
    keysched({4{64'h0123456789ABCDEF}});
    #1 rst_n = 1'b0;
    step(); step();
    `CHK("reset_state", {out_valid, busy, in_ready, out_data, out_tag}, {1'b0, 1'b0, 1'b1, 128'h0, 8'h0})
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      `CHK("idle_hold", {out_valid, busy, in_ready, out_data, out_tag}, {1'b0, 1'b0, 1'b1, 128'h0, 8'h0})
    end
    in_data = enc(128'h0); in_tag = 8'h5A; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    `CHK("rt_busy", {busy, in_ready, out_valid}, 3'b100)
    wait_out(n);
    `CHK("rt_latency", n + 1, 32)
    `CHK("rt_data", out_data, 128'h0)
    `CHK("rt_tag", out_tag, 8'h5A)
    step();
    `CHK("rt_back_idle", {out_valid, busy, in_ready, out_data}, {1'b0, 1'b0, 1'b1, 128'h0})
    for (int j = 0; j < 3; j++) cts[j] = enc(pts[j]);
    in_data = cts[0]; in_tag = 8'h10; in_valid = 1'b1;
    step();
    for (int j = 0; j < 3; j++) begin
      if (j < 2) begin in_data = cts[j+1]; in_tag = 8'(8'h11 + j); end
      else in_valid = 1'b0;
      wait_out(n);
      `CHK("b2b_latency", n + 1, 32)
      `CHK("b2b_data", out_data, pts[j])
      `CHK("b2b_tag", out_tag, 8'(8'h10 + j))
      `CHK("b2b_in_ready_done", in_ready, 1'b1)
      step();
    end
    `CHK("b2b_in_ready_run", bad, 0)
    `CHK("b2b_end_idle", {out_valid, busy, in_ready}, 3'b001)
    out_ready = 1'b0; in_data = enc(pa); in_tag = 8'hA5; in_valid = 1'b1;
    step();
    in_data = enc(pb); in_tag = 8'h3C;
    wait_out(n);
    for (int i = 0; i < 20; i++) begin
      step();
      `CHK("bp_hold", {out_valid, in_ready, busy, out_tag, out_data}, {1'b1, 1'b0, 1'b0, 8'hA5, pa})
    end
    out_ready = 1'b1;
    #1;
    `CHK("bp_in_ready", in_ready, 1'b1)
    step();
    `CHK("bp_same_edge", {out_valid, busy}, 2'b01)
    in_valid = 1'b0;
    wait_out(n);
    `CHK("bp_next_block", {out_tag, out_data}, {8'h3C, pb})
    step();
    in_data = enc(pc); in_tag = 8'h77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    `CHK("rst_mid_run_busy", busy, 1'b1)
    rst_n = 1'b0;
    #1;
    `CHK("rst_run_clear", {out_valid, busy, in_ready, out_data, out_tag}, {1'b0, 1'b0, 1'b1, 128'h0, 8'h0})
    step();
    rst_n = 1'b1;
    in_data = enc(pd); in_tag = 8'h42; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(n);
    `CHK("rst_fresh_block", {out_tag, out_data}, {8'h42, pd})
    `CHK("rst_fresh_latency", n + 1, 32)
    step();
    out_ready = 1'b0; in_data = enc(pc); in_tag = 8'h77; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(n);
    `CHK("rst_done_held", {out_tag, out_data}, {8'h77, pc})
    rst_n = 1'b0;
    #1;
    `CHK("rst_done_clear", {out_valid, busy, in_ready, out_data, out_tag}, {1'b0, 1'b0, 1'b1, 128'h0, 8'h0})
    step();
    rst_n = 1'b1;
    sent = 0; got = 0; cyc = 0; cur = '0;
    while (got < 1000 && cyc < 90000) begin
      if (!in_valid && sent < 1000 && $urandom_range(3) != 0) begin
        ptr = {$urandom, $urandom, $urandom, $urandom};
        in_data = enc(ptr);
        in_tag = 8'($urandom);
        in_valid = 1'b1;
        cur = {in_tag, ptr};
      end
      out_ready = $urandom_range(3) != 0;
      #1;
      take = out_valid && out_ready;
      acc = in_valid && in_ready;
      if (take) begin
        expv = (q.size() > 0) ? q.pop_front() : '0;
        `CHK("rand_block", {out_tag, out_data}, expv)
        got++;
      end
      if (acc) begin
        q.push_back(cur);
        sent++;
      end
      step();
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    `CHK("rand_count", got, 1000)
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
